radix4_online_multiplier: RTL and testbench



---
 rtl/radix4_online_multiplier.sv | 165 ++++++++++++++++
 tb/tb_radix4_online_multiplier.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/radix4_online_multiplier.sv
// radix4_online_multiplier
// Radix-4 signed-digit online multiplier: one digit of each operand per clock,
// MSD first, product digits emitted MSD first after an online delay of `delta`.
// A free-running step counter frames the operation; the frame length is chosen
// at step 0 by full_result_sel (2N+1 product digits or N+1 product digits).
// Optional build macro RADIX4_MULT_INPUT_SAT_EN: when defined, the input code
// 3'b100 is saturated to -3 before use; otherwise it is taken as -4.
module radix4_online_multiplier #(
  parameter int no_of_digits = 4,
  parameter int radix_bits   = 3,
  parameter int radix        = 4,
  parameter int delta        = 2
) (
  input  logic                  clk,
  input  logic                  extern_reset,
  input  logic [radix_bits-1:0] xin,
  input  logic [radix_bits-1:0] yin,
  input  logic                  full_result_sel,
  output logic [radix_bits-1:0] z
);

  // Partial operands keep 2N fractional bits; the residual keeps 2(N+delta)
  // so that the 4^-delta scaling of each operand product is exact.
  localparam int FRAC_XY   = 2 * no_of_digits;
  localparam int XY_W      = FRAC_XY + 4;
  localparam int FRAC_W    = 2 * (no_of_digits + delta);
  localparam int W_W       = FRAC_W + 4;
  localparam int V_W       = W_W + 3;
  localparam int LEN_FULL  = 2 * no_of_digits + delta + 2;
  localparam int LEN_TRUNC = no_of_digits + delta + 2;
  localparam int CNT_W     = $clog2(LEN_FULL);
  localparam int IDX_W     = (no_of_digits > 1) ? $clog2(no_of_digits) : 1;
  localparam int LUT_N     = 1 << IDX_W;
  localparam int DMAX      = radix - 1;

  localparam logic signed [V_W-1:0]        HALF   = V_W'(1 << (FRAC_W - 1));
  localparam logic signed [V_W-1:0]        PMAX   = V_W'(DMAX);
  localparam logic signed [V_W-1:0]        PMIN   = V_W'(-DMAX);
  localparam logic signed [radix_bits-1:0] DMAX_D = radix_bits'(DMAX);
  localparam logic signed [radix_bits-1:0] DMIN_D = radix_bits'(-DMAX);
  localparam logic [radix_bits-1:0]        MIN_CODE = {1'b1, {(radix_bits-1){1'b0}}};

  // Input digit decode; the most negative code is optionally saturated.
  function automatic logic signed [radix_bits-1:0] sat_digit(input logic [radix_bits-1:0] d);
`ifdef RADIX4_MULT_INPUT_SAT_EN
    sat_digit = (d == MIN_CODE) ? DMIN_D : $signed(d);
`else
    sat_digit = (d == MIN_CODE) ? $signed(MIN_CODE) : $signed(d);
`endif
  endfunction

  logic [CNT_W-1:0]             step_reg;
  logic                         full_reg;
  logic signed [W_W-1:0]        w_reg;
  logic signed [XY_W-1:0]       x_acc_reg;
  logic signed [XY_W-1:0]       y_acc_reg;
  logic [radix_bits-1:0]        z_reg;

  logic                         full_cur;
  logic [CNT_W-1:0]             last_step;
  logic                         in_window;
  logic                         emit;
  logic signed [radix_bits-1:0] x_dig;
  logic signed [radix_bits-1:0] y_dig;
  logic signed [radix_bits-1:0] p_dig;
  logic signed [XY_W-1:0]       weight;
  logic signed [XY_W-1:0]       x_dig_xy;
  logic signed [XY_W-1:0]       y_dig_xy;
  logic signed [XY_W-1:0]       x_acc_next;
  logic signed [XY_W-1:0]       y_acc_next;
  logic signed [V_W-1:0]        x_dig_v;
  logic signed [V_W-1:0]        y_dig_v;
  logic signed [V_W-1:0]        x_acc_v;
  logic signed [V_W-1:0]        y_acc_v;
  logic signed [V_W-1:0]        w_v;
  logic signed [V_W-1:0]        v;
  logic signed [V_W-1:0]        p_wide;
  logic signed [W_W-1:0]        p_w;
  logic signed [W_W-1:0]        w_next;
  logic signed [XY_W-1:0]       weight_lut [LUT_N];

  // Weight 4^-(t+1) of input digit t in the partial-operand format.
  genvar gi;
  generate
    for (gi = 0; gi < LUT_N; gi++) begin : g_weight
      if (gi < no_of_digits) begin : g_used
        assign weight_lut[gi] = XY_W'(1 << (FRAC_XY - 2 * (gi + 1)));
      end else begin : g_unused
        assign weight_lut[gi] = '0;
      end
    end
  endgenerate

  // One recurrence step: operand update, residual, digit selection.
  always_comb begin
    full_cur  = (step_reg == '0) ? full_result_sel : full_reg;
    last_step = full_cur ? CNT_W'(LEN_FULL - 1) : CNT_W'(LEN_TRUNC - 1);
    in_window = (step_reg < CNT_W'(no_of_digits));
    emit      = (step_reg >= CNT_W'(delta));

    x_dig  = in_window ? sat_digit(xin) : '0;
    y_dig  = in_window ? sat_digit(yin) : '0;
    weight = in_window ? weight_lut[step_reg[IDX_W-1:0]] : '0;

    x_dig_xy   = {{(XY_W-radix_bits){x_dig[radix_bits-1]}}, x_dig};
    y_dig_xy   = {{(XY_W-radix_bits){y_dig[radix_bits-1]}}, y_dig};
    x_acc_next = x_acc_reg + x_dig_xy * weight;
    y_acc_next = y_acc_reg + y_dig_xy * weight;

    // x_t*Y[t] + y_t*X[t-1]; the 4^-delta factor is implied by the
    // residual having 2*delta more fractional bits than the operands.
    x_dig_v = {{(V_W-radix_bits){x_dig[radix_bits-1]}}, x_dig};
    y_dig_v = {{(V_W-radix_bits){y_dig[radix_bits-1]}}, y_dig};
    x_acc_v = {{(V_W-XY_W){x_acc_reg[XY_W-1]}}, x_acc_reg};
    y_acc_v = {{(V_W-XY_W){y_acc_next[XY_W-1]}}, y_acc_next};
    w_v     = {{(V_W-W_W){w_reg[W_W-1]}}, w_reg};
    v       = (w_v <<< 2) + x_dig_v * y_acc_v + y_dig_v * x_acc_v;

    // Round to nearest (floor(v + 1/2)) and clamp to the digit set.
    p_wide = (v + HALF) >>> FRAC_W;
    if (!emit) begin
      p_dig = '0;
    end else if (p_wide > PMAX) begin
      p_dig = DMAX_D;
    end else if (p_wide < PMIN) begin
      p_dig = DMIN_D;
    end else begin
      p_dig = p_wide[radix_bits-1:0];
    end

    p_w    = {{(W_W-radix_bits){p_dig[radix_bits-1]}}, p_dig};
    w_next = v[W_W-1:0] - (p_w <<< FRAC_W);
  end

  // Frame counter, state registers and the registered product digit.
  always_ff @(posedge clk or posedge extern_reset) begin
    if (extern_reset) begin
      step_reg  <= '0;
      full_reg  <= 1'b0;
      w_reg     <= '0;
      x_acc_reg <= '0;
      y_acc_reg <= '0;
      z_reg     <= '0;
    end else if (step_reg == last_step) begin
      // Idle closing step: clear state so the next frame starts from zero.
      step_reg  <= '0;
      w_reg     <= '0;
      x_acc_reg <= '0;
      y_acc_reg <= '0;
      z_reg     <= '0;
    end else begin
      step_reg <= step_reg + CNT_W'(1);
      if (step_reg == '0) begin
        full_reg <= full_result_sel;
      end
      w_reg     <= w_next;
      x_acc_reg <= x_acc_next;
      y_acc_reg <= y_acc_next;
      z_reg     <= p_dig;
    end
  end

  assign z = z_reg;

endmodule

// File: tb/tb_radix4_online_multiplier.sv
// Directed bench for radix4_online_multiplier (N=4, delta=2).
// Each frame: per-cycle digit/zero/range checks plus an exact value check
// of the collected product digits against the operand product.
module tb_radix4_online_multiplier;

  localparam int N = 4;
  localparam int D = 2;

  logic       clk = 1'b0;
  logic       extern_reset;
  logic [2:0] xin;
  logic [2:0] yin;
  logic       full_result_sel;
  logic [2:0] z;

  int n_tests = 0;
  int n_fail  = 0;
  int xv [N];
  int yv [N];
  int ez [2*N+D+2];

  radix4_online_multiplier dut (
    .clk             (clk),
    .extern_reset    (extern_reset),
    .xin             (xin),
    .yin             (yin),
    .full_result_sel (full_result_sel),
    .z               (z)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int zval();
    logic signed [2:0] zs;
    zs = $signed(z);
    return int'(zs);
  endfunction

  task automatic set_ez_single(input int idx);
    for (int i = 0; i < 2*N+D+2; i++) ez[i] = 0;
    if (idx >= 0) ez[idx] = 1;
  endtask

  // Drive one complete frame and check every cycle plus the final value.
  task automatic run_frame(input string name, input bit full, input bit chk_digits);
    int     len;
    int     kmax;
    int     zi;
    longint s;
    longint xi;
    longint yi;
    longint diff;
    len  = full ? 2*N+D+2 : N+D+2;
    kmax = full ? 2*N : N;
    s    = 0;
    xi   = 0;
    yi   = 0;
    for (int i = 0; i < N; i++) begin
      xi = xi * 4 + xv[i];
      yi = yi * 4 + yv[i];
    end
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      zi = zval();
      if (chk_digits) begin
        check_val($sformatf("%s_c%0d", name, c), zi, ez[c]);
      end else if (c >= D+1 && c <= kmax+D+1) begin
        check_val($sformatf("%s_range_c%0d", name, c), (zi >= -3 && zi <= 3), 1);
      end else begin
        check_val($sformatf("%s_zero_c%0d", name, c), zi, 0);
      end
      if (c >= D+1 && c <= kmax+D+1) s = s * 4 + zi;
      // full_result_sel must only matter at step 0
      full_result_sel = (c == 0) ? full : ~full;
      if (c < N) begin
        xin = 3'(xv[c]);
        yin = 3'(yv[c]);
      end else begin
        xin = 3'($urandom_range(1, 7));
        yin = 3'($urandom_range(1, 7));
      end
    end
    if (full) begin
      check_val($sformatf("%s_value", name), s, 4 * xi * yi);
    end else begin
      diff = xi * yi - s * (4 ** (N-1));
      if (diff < 0) diff = -diff;
      check_val($sformatf("%s_trunc_err", name), (diff <= (4 ** (N-1)) / 2), 1);
    end
    $display("[TB] frame %s full=%0d Xi*Yi=%0d digits=%0d", name, full, xi * yi, s);
  endtask

  initial begin
    extern_reset    = 1'b1;
    xin             = '0;
    yin             = '0;
    full_result_sel = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_z", zval(), 0);
    @(posedge clk);
    #2 extern_reset = 1'b0;

    xv = '{0, 0, 0, 0};
    yv = '{0, 0, 0, 0};
    set_ez_single(-1);
    run_frame("zero", 1'b1, 1'b1);

    xv = '{2, 0, 0, 0};
    yv = '{2, 0, 0, 0};
    set_ez_single(3);
    run_frame("half", 1'b1, 1'b1);

    xv = '{3, 3, 3, 3};
    yv = '{3, 3, 3, 3};
    run_frame("max", 1'b1, 1'b0);

    xv = '{-3, -3, -3, -3};
    yv = '{3, 3, 3, 3};
    run_frame("mixed", 1'b1, 1'b0);

    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < N; i++) begin
        xv[i] = int'($urandom_range(0, 6)) - 3;
        yv[i] = int'($urandom_range(0, 6)) - 3;
      end
      run_frame($sformatf("rand%0d", f), 1'b1, 1'b0);
    end

    xv = '{2, 0, 0, 0};
    yv = '{2, 0, 0, 0};
    set_ez_single(3);
    run_frame("trunc", 1'b0, 1'b1);
    run_frame("trunc_next", 1'b0, 1'b1);

    // Reset in the middle of a frame whose p_2 = 1 shows in cycle 5.
    xv = '{2, 0, 0, 0};
    yv = '{0, 0, 2, 0};
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (c == 5) check_val("pre_reset_p2", zval(), 1);
      full_result_sel = 1'b1;
      if (c < N) begin
        xin = 3'(xv[c]);
        yin = 3'(yv[c]);
      end else begin
        xin = '0;
        yin = '0;
      end
    end
    extern_reset = 1'b1;
    #1 check_val("reset_mid_z", zval(), 0);
    $display("[TB] frame reset_mid asserted at step 5");
    xin = '0;
    yin = '0;
    repeat (2) @(posedge clk);
    #2 extern_reset = 1'b0;

    xv = '{2, 0, 0, 0};
    yv = '{2, 0, 0, 0};
    set_ez_single(3);
    run_frame("after_reset", 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
